apb_mac_master: RTL and testbench

//  APB requester that drives the apb_mac_design completer from a simple local command port.
//  - Accepts one read/write command at a time.
//  - Runs the APB SETUP/ACCESS phases and waits on PREADY.
//  - Returns PRDATA/PSLVERR as a single-cycle response.
//  - Lets an on-chip controller load operands and fetch MAC results without a testbench BFM.

---
 rtl/apb_mac_pkg.sv | 23 ++
 rtl/apb_mac_master_timer.sv | 43 ++++
 rtl/apb_mac_master.sv | 152 +++++++++++++++
 tb/tb_apb_mac_master.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_mac_pkg.sv
// Shared definitions for the APB MAC requester: FSM state encoding,
// register offsets of the apb_mac_design completer, and a helper that
// sizes the wait-state counter used by the optional timeout logic.
package apb_mac_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    // Byte offsets of the MAC completer registers, relative to SLAVE_BASE
    localparam logic [31:0] MAC_A_OFF    = 32'h0000_0000;
    localparam logic [31:0] MAC_B_OFF    = 32'h0000_0004;
    localparam logic [31:0] MAC_ACC_OFF  = 32'h0000_0008;
    localparam logic [31:0] MAC_CTRL_OFF = 32'h0000_000C;

    // Counter width needed to hold values 0..cycles
    function automatic int timeout_w(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/apb_mac_master_timer.sv
// Wait-state counter for the APB requester. Counts ACCESS cycles in which
// the completer holds PREADY low and flags the cycle that is the
// TIMEOUT_CYCLES-th such wait, so the requester aborts at that edge.
// Only instantiated when APB_MAC_MASTER_TIMEOUT_EN is defined.
module apb_mac_master_timer
    import apb_mac_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic wait_i,
    output logic timeout_o
);

    localparam int TW = timeout_w(TIMEOUT_CYCLES);

    logic [TW-1:0] count_q;
    logic [TW-1:0] count_d;

    assign timeout_o = wait_i && (count_q == TW'(TIMEOUT_CYCLES - 1));

    // Next count: restart on a newly accepted command, advance on each wait cycle
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (wait_i) begin
            count_d = count_q + TW'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/apb_mac_master.sv
// APB requester driving the apb_mac_design completer from a one-deep local
// command port. Runs SETUP/ACCESS, waits on PREADY and returns PRDATA and
// PSLVERR as a single-cycle response pulse. All outputs except cmd_ready
// are registered.
// Optional feature: define APB_MAC_MASTER_TIMEOUT_EN to abort a transfer
// with rsp_err=1 after TIMEOUT_CYCLES consecutive wait states.
module apb_mac_master
    import apb_mac_pkg::*;
#(
    parameter int                    ADDR_WIDTH     = 32,
    parameter int                    DATA_WIDTH     = 32,
    parameter logic [ADDR_WIDTH-1:0] SLAVE_BASE     = '0,
    parameter int                    TIMEOUT_CYCLES = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic                  PSELx,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);

    apb_state_e            state_q,     state_d;
    logic [ADDR_WIDTH-1:0] paddr_q,     paddr_d;
    logic                  psel_q,      psel_d;
    logic                  penable_q,   penable_d;
    logic                  pwrite_q,    pwrite_d;
    logic [DATA_WIDTH-1:0] pwdata_q,    pwdata_d;
    logic                  rspValid_q,  rspValid_d;
    logic [DATA_WIDTH-1:0] rspRdata_q,  rspRdata_d;
    logic                  rspErr_q,    rspErr_d;
    logic                  timeoutHit;

`ifdef APB_MAC_MASTER_TIMEOUT_EN
    logic timerClear;
    logic timerWait;

    assign timerClear = (state_q == IDLE) && cmd_valid;
    assign timerWait  = (state_q == ACCESS) && !PREADY;

    apb_mac_master_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk_i     (PCLK),
        .rst_i     (PRESET),
        .clear_i   (timerClear),
        .wait_i    (timerWait),
        .timeout_o (timeoutHit)
    );
`else
    assign timeoutHit = 1'b0;
`endif

    assign cmd_ready = (state_q == IDLE);
    assign PADDR     = paddr_q;
    assign PSELx     = psel_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = pwrite_q;
    assign PWDATA    = pwdata_q;
    assign rsp_valid = rspValid_q;
    assign rsp_rdata = rspRdata_q;
    assign rsp_err   = rspErr_q;

    // Next-state and next-output logic; address/data hold their last values after completion
    always_comb begin
        state_d    = state_q;
        paddr_d    = paddr_q;
        psel_d     = psel_q;
        penable_d  = penable_q;
        pwrite_d   = pwrite_q;
        pwdata_d   = pwdata_q;
        rspValid_d = 1'b0;
        rspRdata_d = rspRdata_q;
        rspErr_d   = rspErr_q;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    paddr_d   = SLAVE_BASE + cmd_addr;
                    pwrite_d  = cmd_write;
                    pwdata_d  = cmd_write ? cmd_wdata : '0;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    state_d   = SETUP;
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                state_d   = ACCESS;
            end
            ACCESS: begin
                if (PREADY) begin
                    rspValid_d = 1'b1;
                    rspRdata_d = pwrite_q ? '0 : PRDATA;
                    rspErr_d   = PSLVERR;
                    psel_d     = 1'b0;
                    penable_d  = 1'b0;
                    state_d    = IDLE;
                end else if (timeoutHit) begin
                    rspValid_d = 1'b1;
                    rspRdata_d = '0;
                    rspErr_d   = 1'b1;
                    psel_d     = 1'b0;
                    penable_d  = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: begin
                psel_d    = 1'b0;
                penable_d = 1'b0;
                state_d   = IDLE;
            end
        endcase
    end

    // State and output registers; reset drops any transfer in flight without a response
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q    <= IDLE;
            paddr_q    <= '0;
            psel_q     <= 1'b0;
            penable_q  <= 1'b0;
            pwrite_q   <= 1'b0;
            pwdata_q   <= '0;
            rspValid_q <= 1'b0;
            rspRdata_q <= '0;
            rspErr_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            paddr_q    <= paddr_d;
            psel_q     <= psel_d;
            penable_q  <= penable_d;
            pwrite_q   <= pwrite_d;
            pwdata_q   <= pwdata_d;
            rspValid_q <= rspValid_d;
            rspRdata_q <= rspRdata_d;
            rspErr_q   <= rspErr_d;
        end
    end

endmodule

// File: tb/tb_apb_mac_master.sv
// Testbench for apb_mac_master. A completer model answers APB transfers from
// a queue of per-transfer settings (wait states, read data, error) and checks
// PADDR/PWRITE/PWDATA on every ACCESS cycle; a response monitor pops the
// expected rsp (data, error, arrival cycle) whenever rsp_valid is seen.
module tb_apb_mac_master;

    localparam logic [31:0] BASE    = 32'h1000_0000;
    localparam int          TIMEOUT = 16;

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
        int          waits;
        logic [31:0] rdata;
        logic        err;
    } slv_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } rsp_t;

    logic        PCLK;
    logic        PRESET;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] PADDR;
    logic        PSELx;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA  = 32'hDEAD_BEEF;
    logic        PREADY  = 1'b0;
    logic        PSLVERR = 1'b0;

    slv_t slaveQ[$];
    rsp_t rspQ[$];
    int   vectors = 0;
    int   misses  = 0;
    int   cyc     = 0;
    int   waitCnt = 0;

    apb_mac_master #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .SLAVE_BASE     (BASE),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .PCLK      (PCLK),
        .PRESET    (PRESET),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .PADDR     (PADDR),
        .PSELx     (PSELx),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR)
    );

    initial begin
        PCLK = 1'b0;
        forever #5 PCLK = ~PCLK;
    end

    always @(posedge PCLK) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            misses++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, actual, expected, $time);
        end
    endtask

    // Issue one command; expected completer view and response are queued at acceptance
    task automatic applyStimulus(input logic wr, input logic [31:0] offset, input logic [31:0] wdata,
                                 input logic [31:0] expAddr, input int waits,
                                 input logic [31:0] slvRdata, input logic slvErr,
                                 input logic [31:0] expRdata, input logic expErr, input int rspLat,
                                 input bit expectRsp, input bit hold, output int acceptCyc);
        slv_t s;
        rsp_t r;
        for (int i = 0; i < 50 && cmd_ready !== 1'b1; i++) @(negedge PCLK);
        if (cmd_ready !== 1'b1) checkOutput("cmd_ready wait", {31'b0, cmd_ready}, 32'h1);
        cmd_write = wr;
        cmd_addr  = offset;
        cmd_wdata = wdata;
        cmd_valid = 1'b1;
        @(posedge PCLK);
        #1;
        acceptCyc = cyc;
        s.addr  = expAddr;
        s.wr    = wr;
        s.wdata = wr ? wdata : 32'h0;
        s.waits = waits;
        s.rdata = slvRdata;
        s.err   = slvErr;
        slaveQ.push_back(s);
        if (expectRsp) begin
            r.rdata = expRdata;
            r.err   = expErr;
            r.cyc   = acceptCyc + rspLat;
            rspQ.push_back(r);
        end
        if (!hold) cmd_valid = 1'b0;
    endtask

    task automatic drainRsp();
        for (int i = 0; i < 200 && rspQ.size() != 0; i++) @(negedge PCLK);
        #1;
        checkOutput("rsp drain", rspQ.size(), 0);
    endtask

    task automatic pulseReset();
        #2 PRESET = 1'b1;
        @(negedge PCLK);
        #2 PRESET = 1'b0;
    endtask

    // Completer model: inserts wait states, returns data/error, checks stable address phase
    always @(negedge PCLK) begin
        slv_t cur;
        slv_t dropped;
        if (PRESET) begin
            slaveQ.delete();
            waitCnt = 0;
            PREADY  = 1'b0;
            PSLVERR = 1'b0;
            PRDATA  = 32'hDEAD_BEEF;
        end else if (PSELx && PENABLE) begin
            if (slaveQ.size() == 0) begin
                checkOutput("unexpected access", 32'h1, 32'h0);
                PREADY = 1'b0;
            end else begin
                cur = slaveQ[0];
                checkOutput("PADDR", PADDR, cur.addr);
                checkOutput("PWRITE", {31'b0, PWRITE}, {31'b0, cur.wr});
                checkOutput("PWDATA", PWDATA, cur.wdata);
                if (waitCnt < cur.waits) begin
                    PREADY  = 1'b0;
                    PRDATA  = ~cur.rdata;
                    PSLVERR = ~cur.err;
                    waitCnt++;
                end else begin
                    PREADY  = 1'b1;
                    PRDATA  = cur.rdata;
                    PSLVERR = cur.err;
                    dropped = slaveQ.pop_front();
                    waitCnt = 0;
                end
            end
        end else begin
            PREADY  = 1'b0;
            PSLVERR = 1'b0;
            PRDATA  = 32'hDEAD_BEEF;
            if (waitCnt != 0) begin
                dropped = slaveQ.pop_front();
                waitCnt = 0;
            end
        end
    end

    // Response monitor: every rsp_valid pulse must match the oldest expectation
    always @(negedge PCLK) begin
        rsp_t e;
        if (!PRESET && rsp_valid === 1'b1) begin
            if (rspQ.size() == 0) begin
                checkOutput("unexpected rsp_valid", 32'h1, 32'h0);
            end else begin
                e = rspQ.pop_front();
                checkOutput("rsp_rdata", rsp_rdata, e.rdata);
                checkOutput("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
                checkOutput("rsp cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        int acc;
        int acc2;
        PRESET    = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = 32'h0;
        cmd_wdata = 32'h0;
        repeat (2) @(negedge PCLK);

        // Reset values
        checkOutput("reset PADDR", PADDR, 32'h0);
        checkOutput("reset PSELx", {31'b0, PSELx}, 32'h0);
        checkOutput("reset PENABLE", {31'b0, PENABLE}, 32'h0);
        checkOutput("reset PWRITE", {31'b0, PWRITE}, 32'h0);
        checkOutput("reset PWDATA", PWDATA, 32'h0);
        checkOutput("reset rsp_valid", {31'b0, rsp_valid}, 32'h0);
        checkOutput("reset rsp_rdata", rsp_rdata, 32'h0);
        checkOutput("reset rsp_err", {31'b0, rsp_err}, 32'h0);
        #2 PRESET = 1'b0;
        @(negedge PCLK);
        checkOutput("cmd_ready after reset", {31'b0, cmd_ready}, 32'h1);

        // 1: single write, no wait states, phase timing
        applyStimulus(1'b1, apb_mac_pkg::MAC_A_OFF, 32'h0000_0005, 32'h1000_0000, 0,
                      32'hFFFF_FFFF, 1'b0, 32'h0, 1'b0, 2, 1'b1, 1'b0, acc);
        @(negedge PCLK);
        checkOutput("T1 PSELx N+1", {31'b0, PSELx}, 32'h1);
        checkOutput("T1 PENABLE N+1", {31'b0, PENABLE}, 32'h0);
        checkOutput("T1 cmd_ready N+1", {31'b0, cmd_ready}, 32'h0);
        @(negedge PCLK);
        checkOutput("T1 PSELx N+2", {31'b0, PSELx}, 32'h1);
        checkOutput("T1 PENABLE N+2", {31'b0, PENABLE}, 32'h1);
        checkOutput("T1 PWDATA N+2", PWDATA, 32'h0000_0005);
        @(negedge PCLK);
        checkOutput("T1 PSELx N+3", {31'b0, PSELx}, 32'h0);
        checkOutput("T1 PENABLE N+3", {31'b0, PENABLE}, 32'h0);
        checkOutput("T1 rsp_valid N+3", {31'b0, rsp_valid}, 32'h1);
        drainRsp();

        // 2: read with three wait states; address phase held after completion
        applyStimulus(1'b0, apb_mac_pkg::MAC_ACC_OFF, 32'h1234_5678, 32'h1000_0008, 3,
                      32'h0000_0019, 1'b0, 32'h0000_0019, 1'b0, 5, 1'b1, 1'b0, acc);
        drainRsp();
        checkOutput("T2 PADDR held", PADDR, 32'h1000_0008);
        checkOutput("T2 PSELx idle", {31'b0, PSELx}, 32'h0);

        // 3: base offset and PSLVERR on a read and on a write
        applyStimulus(1'b0, apb_mac_pkg::MAC_B_OFF, 32'h0, 32'h1000_0004, 1,
                      32'h0000_00AA, 1'b1, 32'h0000_00AA, 1'b1, 3, 1'b1, 1'b0, acc);
        drainRsp();
        applyStimulus(1'b1, apb_mac_pkg::MAC_CTRL_OFF, 32'h0000_0001, 32'h1000_000C, 0,
                      32'h0000_0055, 1'b1, 32'h0, 1'b1, 2, 1'b1, 1'b0, acc);
        drainRsp();

        // Address wraps at 32 bits
        applyStimulus(1'b1, 32'hF000_0010, 32'hCAFE_F00D, 32'h0000_0010, 2,
                      32'h0, 1'b0, 32'h0, 1'b0, 4, 1'b1, 1'b0, acc);
        drainRsp();

        // 4: back-to-back commands with cmd_valid held high
        applyStimulus(1'b1, apb_mac_pkg::MAC_A_OFF, 32'h0000_0003, 32'h1000_0000, 0,
                      32'h0000_0077, 1'b0, 32'h0, 1'b0, 2, 1'b1, 1'b1, acc);
        @(negedge PCLK);
        checkOutput("T4 cmd_ready N+1", {31'b0, cmd_ready}, 32'h0);
        @(negedge PCLK);
        checkOutput("T4 cmd_ready N+2", {31'b0, cmd_ready}, 32'h0);
        @(negedge PCLK);
        checkOutput("T4 PSELx N+3", {31'b0, PSELx}, 32'h0);
        checkOutput("T4 cmd_ready N+3", {31'b0, cmd_ready}, 32'h1);
        applyStimulus(1'b0, apb_mac_pkg::MAC_ACC_OFF, 32'h0, 32'h1000_0008, 0,
                      32'h0000_001E, 1'b0, 32'h0000_001E, 1'b0, 2, 1'b1, 1'b0, acc2);
        checkOutput("T4 second accept", acc2, acc + 3);
        @(negedge PCLK);
        checkOutput("T4 PSELx N+4", {31'b0, PSELx}, 32'h1);
        checkOutput("T4 PENABLE N+4", {31'b0, PENABLE}, 32'h0);
        drainRsp();

        // 5: reset during ACCESS drops the transfer
        applyStimulus(1'b0, apb_mac_pkg::MAC_ACC_OFF, 32'h0, 32'h1000_0008, 10,
                      32'h0000_0099, 1'b0, 32'h0, 1'b0, 0, 1'b0, 1'b0, acc);
        repeat (2) @(negedge PCLK);
        checkOutput("T5 in ACCESS", {31'b0, PSELx & PENABLE}, 32'h1);
        #2 PRESET = 1'b1;
        #1;
        checkOutput("T5 async PSELx", {31'b0, PSELx}, 32'h0);
        checkOutput("T5 async PENABLE", {31'b0, PENABLE}, 32'h0);
        checkOutput("T5 async rsp_valid", {31'b0, rsp_valid}, 32'h0);
        checkOutput("T5 async PADDR", PADDR, 32'h0);
        @(negedge PCLK);
        #2 PRESET = 1'b0;
        @(negedge PCLK);
        checkOutput("T5 cmd_ready", {31'b0, cmd_ready}, 32'h1);
        repeat (15) @(negedge PCLK);
        checkOutput("T5 PSELx idle", {31'b0, PSELx}, 32'h0);

        // 6: completer never ready
`ifdef APB_MAC_MASTER_TIMEOUT_EN
        applyStimulus(1'b0, apb_mac_pkg::MAC_ACC_OFF, 32'h0, 32'h1000_0008, 1000,
                      32'h0000_0042, 1'b0, 32'h0, 1'b1, TIMEOUT + 1, 1'b1, 1'b0, acc);
        drainRsp();
        @(negedge PCLK);
        checkOutput("T6 PSELx after abort", {31'b0, PSELx}, 32'h0);
        checkOutput("T6 cmd_ready after abort", {31'b0, cmd_ready}, 32'h1);
`else
        applyStimulus(1'b0, apb_mac_pkg::MAC_ACC_OFF, 32'h0, 32'h1000_0008, 1000,
                      32'h0000_0042, 1'b0, 32'h0, 1'b0, 0, 1'b0, 1'b0, acc);
        repeat (100) @(negedge PCLK);
        checkOutput("T6 PSELx cycle 100", {31'b0, PSELx}, 32'h1);
        checkOutput("T6 PENABLE cycle 100", {31'b0, PENABLE}, 32'h1);
        checkOutput("T6 cmd_ready cycle 100", {31'b0, cmd_ready}, 32'h0);
        pulseReset();
`endif

        repeat (5) @(negedge PCLK);
        #1;
        checkOutput("pending rsp", rspQ.size(), 0);
        checkOutput("pending access", slaveQ.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
        $finish;
    end

endmodule
